neuron_sweep_ctrl: RTL and testbench

//  Sequencer directly upstream of if_neuron. Accepts one event at a time and

---
 rtl/neuron_sweep_ctrl_pkg.sv | 29 ++
 rtl/neuron_sweep_ctrl_if.sv | 27 ++
 rtl/neuron_sweep_ctrl_spk_fifo.sv | 54 +++++
 rtl/neuron_sweep_ctrl.sv | 156 +++++++++++++++
 tb/tb_neuron_sweep_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_sweep_ctrl_pkg.sv
// Shared encodings and word layout for the neuron sweep sequencer.
package neuron_sweep_ctrl_pkg;

  localparam int unsigned MEM_W      = 12;
  localparam int unsigned CNT_W      = 7;
  localparam int unsigned W_W        = 8;
  localparam int unsigned NRN_WORD_W = CNT_W + MEM_W;

  typedef enum logic [1:0] {
    EVT_NEURON = 2'd0,
    EVT_TSTEP  = 2'd1,
    EVT_TREF   = 2'd2,
    EVT_RSVD   = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } sweep_state_e;

  // Neuron SRAM word: spike count in the upper bits, membrane state below.
  function automatic logic [NRN_WORD_W-1:0] pack_nrn_word(input logic [CNT_W-1:0] cnt,
                                                          input logic [MEM_W-1:0] state);
    return {cnt, state};
  endfunction

endpackage

// File: rtl/neuron_sweep_ctrl_if.sv
// Event input and spike AER output handshakes of the sweep sequencer.
interface neuron_sweep_ctrl_if
  import neuron_sweep_ctrl_pkg::*;
#(
  parameter int unsigned PRE_AW = 10,
  parameter int unsigned NRN_AW = 8
);

  logic              evt_valid;
  logic              evt_ready;
  evt_type_e         evt_type;
  logic [PRE_AW-1:0] evt_addr;
  logic              spk_valid;
  logic              spk_ready;
  logic [NRN_AW-1:0] spk_addr;

  modport master (
    output evt_valid, evt_type, evt_addr, spk_ready,
    input  evt_ready, spk_valid, spk_addr
  );

  modport slave (
    input  evt_valid, evt_type, evt_addr, spk_ready,
    output evt_ready, spk_valid, spk_addr
  );

endinterface

// File: rtl/neuron_sweep_ctrl_spk_fifo.sv
// Synchronous FIFO holding spiking neuron indices until the next layer takes them.
module neuron_sweep_ctrl_spk_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees the slot in the same cycle, so push-while-full is accepted then.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/neuron_sweep_ctrl.sv
// Per-event sweep over all post-synaptic neurons: SRAM read, if_neuron update, write-back,
// and spike queueing for the next layer.
module neuron_sweep_ctrl
  import neuron_sweep_ctrl_pkg::*;
#(
  parameter int unsigned N_NEUR    = 256,
  parameter int unsigned NRN_AW    = 8,
  parameter int unsigned PRE_AW    = 10,
  parameter int unsigned SPK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  neuron_sweep_ctrl_if.slave           bus,
  output logic                         o_syn_re,
  output logic [PRE_AW+NRN_AW-1:0]     o_syn_addr,
  input  logic [W_W-1:0]               i_syn_rdata,
  output logic                         o_nrn_re,
  output logic [NRN_AW-1:0]            o_nrn_addr,
  input  logic [NRN_WORD_W-1:0]        i_nrn_rdata,
  output logic                         o_nrn_we,
  output logic [NRN_WORD_W-1:0]        o_nrn_wdata,
  output logic [MEM_W-1:0]             o_state_core,
  output logic [CNT_W-1:0]             o_post_spike_cnt,
  output logic [W_W-1:0]               o_syn_weight,
  output logic                         o_neuron_event,
  output logic                         o_time_step_event,
  output logic                         o_time_ref_event,
  input  logic [MEM_W-1:0]             i_state_core_next,
  input  logic [CNT_W-1:0]             i_post_spike_cnt_next,
  input  logic                         i_spike_out,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned CW = $clog2(SPK_DEPTH) + 1;
  localparam logic [NRN_AW-1:0] LAST_J = NRN_AW'(N_NEUR - 1);

  sweep_state_e      r_state, w_state_d;
  evt_type_e         r_type, w_type_d;
  logic [PRE_AW-1:0] r_pre, w_pre_d;
  logic [NRN_AW-1:0] r_j, w_j_d;
  logic [NRN_AW-1:0] r_s2_idx;
  logic              r_s2_valid;
  logic              r_ready_en;
  logic              w_accept;
  logic              w_issue;
  logic              w_free_ok;
  logic              w_syn_re;
  logic              w_push;
  logic              w_pop;
  logic              w_spk_valid;
  logic [NRN_AW-1:0] w_spk_data;
  logic [CW-1:0]     w_spk_count;

  // Holds evt_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ready_en <= 1'b0;
    else        r_ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_type     <= EVT_NEURON;
      r_pre      <= '0;
      r_j        <= '0;
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_type     <= w_type_d;
      r_pre      <= w_pre_d;
      r_j        <= w_j_d;
      r_s2_valid <= w_issue;
      if (w_issue) r_s2_idx <= r_j;
    end
  end

  // Two issued-but-unpushed spikes can be in flight, so keep two slots in reserve.
  assign w_free_ok = (32'(w_spk_count) + 32'd2) <= SPK_DEPTH;

  always_comb begin
    w_state_d = r_state;
    w_type_d  = r_type;
    w_pre_d   = r_pre;
    w_j_d     = r_j;
    w_accept  = 1'b0;
    w_issue   = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_accept = bus.evt_valid && r_ready_en;
        if (w_accept) begin
          w_type_d  = bus.evt_type;
          w_pre_d   = bus.evt_addr;
          w_j_d     = '0;
          w_state_d = (bus.evt_type == EVT_RSVD) ? StDone : StSweep;
        end
      end
      StSweep: begin
        if (w_free_ok) begin
          w_issue = 1'b1;
          w_j_d   = r_j + 1'b1;
          if (r_j == LAST_J) w_state_d = StDrain;
        end
      end
      StDrain: w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.evt_ready = (r_state == StIdle) && r_ready_en;
  assign o_busy        = (r_state == StSweep) || (r_state == StDrain);
  assign o_done        = (r_state == StDone);

  // Stage 1: reads for neuron j.
  assign w_syn_re   = w_issue && (r_type == EVT_NEURON);
  assign o_syn_re   = w_syn_re;
  assign o_syn_addr = w_syn_re ? {r_pre, r_j} : '0;
  assign o_nrn_re   = w_issue;

  // 1R1W wrapper: while a write is presented the read target is the next index in sweep order.
  assign o_nrn_addr = r_s2_valid ? r_s2_idx : (w_issue ? r_j : '0);

  // Stage 2: feed if_neuron and write back neuron j-1.
  assign o_nrn_we          = r_s2_valid;
  assign o_nrn_wdata       = r_s2_valid ? pack_nrn_word(i_post_spike_cnt_next, i_state_core_next)
                                        : '0;
  assign o_state_core      = r_s2_valid ? i_nrn_rdata[MEM_W-1:0] : '0;
  assign o_post_spike_cnt  = r_s2_valid ? i_nrn_rdata[NRN_WORD_W-1:MEM_W] : '0;
  assign o_syn_weight      = (r_s2_valid && (r_type == EVT_NEURON)) ? i_syn_rdata : '0;
  assign o_neuron_event    = r_s2_valid && (r_type == EVT_NEURON);
  assign o_time_step_event = r_s2_valid && (r_type == EVT_TSTEP);
  assign o_time_ref_event  = r_s2_valid && (r_type == EVT_TREF);

  assign w_push = r_s2_valid && (r_type == EVT_TSTEP) && i_spike_out;
  assign w_pop  = w_spk_valid && bus.spk_ready;

  neuron_sweep_ctrl_spk_fifo #(
    .DEPTH (SPK_DEPTH),
    .WIDTH (NRN_AW)
  ) u_spk_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_s2_idx),
    .i_pop   (w_pop),
    .o_data  (w_spk_data),
    .o_valid (w_spk_valid),
    .o_count (w_spk_count)
  );

  assign bus.spk_valid = w_spk_valid;
  assign bus.spk_addr  = w_spk_valid ? w_spk_data : '0;

endmodule

// File: tb/tb_neuron_sweep_ctrl.sv
// Bench for neuron_sweep_ctrl: SRAM and if_neuron models, scoreboarded writes and spikes.
module tb_neuron_sweep_ctrl;
  import neuron_sweep_ctrl_pkg::*;

  localparam int unsigned N_NEUR    = 4;
  localparam int unsigned NRN_AW    = 2;
  localparam int unsigned PRE_AW    = 10;
  localparam int unsigned SPK_DEPTH = 4;
  localparam int unsigned SYN_AW    = PRE_AW + NRN_AW;
  localparam logic [11:0] THR       = 12'h100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  neuron_sweep_ctrl_if #(.PRE_AW(PRE_AW), .NRN_AW(NRN_AW)) u_if ();

  logic              syn_re, nrn_re, nrn_we;
  logic [SYN_AW-1:0] syn_addr;
  logic [7:0]        syn_rdata;
  logic [NRN_AW-1:0] nrn_addr;
  logic [18:0]       nrn_rdata, nrn_wdata;
  logic [11:0]       state_core, state_next;
  logic [6:0]        spk_cnt, cnt_next;
  logic [7:0]        syn_weight;
  logic              ev_neuron, ev_tstep, ev_tref, spike_out, busy, done;

  neuron_sweep_ctrl #(
    .N_NEUR(N_NEUR), .NRN_AW(NRN_AW), .PRE_AW(PRE_AW), .SPK_DEPTH(SPK_DEPTH)
  ) u_dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .bus                   (u_if),
    .o_syn_re              (syn_re),
    .o_syn_addr            (syn_addr),
    .i_syn_rdata           (syn_rdata),
    .o_nrn_re              (nrn_re),
    .o_nrn_addr            (nrn_addr),
    .i_nrn_rdata           (nrn_rdata),
    .o_nrn_we              (nrn_we),
    .o_nrn_wdata           (nrn_wdata),
    .o_state_core          (state_core),
    .o_post_spike_cnt      (spk_cnt),
    .o_syn_weight          (syn_weight),
    .o_neuron_event        (ev_neuron),
    .o_time_step_event     (ev_tstep),
    .o_time_ref_event      (ev_tref),
    .i_state_core_next     (state_next),
    .i_post_spike_cnt_next (cnt_next),
    .i_spike_out           (spike_out),
    .o_busy                (busy),
    .o_done                (done)
  );

  // SRAM models; bd_* is a backdoor preset applied while the DUT is idle.
  logic [18:0]       nrn_mem [N_NEUR];
  logic [7:0]        syn_mem [1 << SYN_AW];
  logic              bd_en = 1'b0;
  logic [18:0]       bd_word [N_NEUR];
  logic [NRN_AW-1:0] raddr;

  assign raddr = nrn_we ? nrn_addr + 1'b1 : nrn_addr;

  initial for (int a = 0; a < (1 << SYN_AW); a++) syn_mem[a] = (a / 4 == 3) ? 8'h10 : 8'h7F;

  always @(posedge clk) begin
    if (bd_en) for (int k = 0; k < N_NEUR; k++) nrn_mem[k] <= bd_word[k];
    else if (nrn_we) nrn_mem[nrn_addr] <= nrn_wdata;
    if (nrn_re) nrn_rdata <= nrn_mem[raddr];
    if (syn_re) syn_rdata <= syn_mem[syn_addr];
  end

  // if_neuron model; spike_out is raised whenever state is over threshold, whatever the strobe.
  always_comb begin
    state_next = state_core;
    cnt_next   = spk_cnt;
    spike_out  = ($signed(state_core) >= $signed(THR));
    if (ev_neuron) state_next = state_core + {{2{syn_weight[7]}}, syn_weight, 2'b00};
    if (ev_tstep && spike_out) begin
      state_next = 12'h000;
      cnt_next   = spk_cnt + 7'd1;
    end
    if (ev_tref) begin
      state_next = 12'h000;
      cnt_next   = 7'd0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_wr [$];
  logic [1:0]  exp_spk [$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] outs_vec();
    return {busy, done, nrn_re, nrn_we, syn_re, ev_neuron, ev_tstep, ev_tref, u_if.spk_valid,
            u_if.evt_ready, |nrn_addr, |syn_addr, |nrn_wdata, |state_core, |syn_weight,
            |spk_cnt};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (nrn_we) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL nrn_write: got addr %0d data 0x%0h, expected no write", nrn_addr,
                   nrn_wdata);
        end else check("nrn_write", {11'd0, nrn_addr, nrn_wdata}, exp_wr.pop_front());
      end
      if (u_if.spk_valid && u_if.spk_ready) begin
        if (exp_spk.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spk_addr: got %0d, expected no spike", u_if.spk_addr);
        end else check("spk_addr", u_if.spk_addr, exp_spk.pop_front());
      end
    end
  end

  task automatic push_wr(input int j, input logic [18:0] d);
    exp_wr.push_back({NRN_AW'(j), d});
  endtask

  task automatic preset();
    @(negedge clk);
    bd_en = 1'b1;
    @(posedge clk);
    #1 bd_en = 1'b0;
  endtask

  task automatic preset_all(input logic [18:0] w);
    for (int k = 0; k < N_NEUR; k++) bd_word[k] = w;
    preset();
  endtask

  task automatic accept_evt(input evt_type_e t, input logic [PRE_AW-1:0] a);
    int i = 0;
    while (!u_if.evt_ready && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("evt_ready_wait", u_if.evt_ready, 1);
    u_if.evt_valid = 1'b1;
    u_if.evt_type  = t;
    u_if.evt_addr  = a;
    @(posedge clk);
    #1 u_if.evt_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int lat);
    int i = 0;
    lat = -1;
    while (lat < 0 && i < bound) begin
      @(negedge clk);
      i++;
      if (done) lat = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nre;
    int i;
    u_if.evt_valid = 1'b0;
    u_if.evt_type  = EVT_NEURON;
    u_if.evt_addr  = '0;
    u_if.spk_ready = 1'b1;
    for (int k = 0; k < N_NEUR; k++) bd_word[k] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", outs_vec(), 0);
    check("reset_evt_ready", u_if.evt_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1) NEURON pre=3 onto zero state: every word becomes 0x040.
    preset_all(19'h0);
    for (int j = 0; j < N_NEUR; j++) push_wr(j, 19'h00040);
    accept_evt(EVT_NEURON, 10'd3);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_evt_ready_low", u_if.evt_ready, 0);
    wait_done(20, lat);
    check("t1_latency", lat + 1, 6);
    check("t1_busy_at_done", busy, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_evt_ready", u_if.evt_ready, 1);

    // 2) TSTEP with mixed states against threshold 0x100.
    bd_word[0] = 19'h00300;
    bd_word[1] = 19'h000FF;
    bd_word[2] = 19'h00100;
    bd_word[3] = 19'h007FF;
    preset();
    push_wr(0, 19'h01000);
    push_wr(1, 19'h000FF);
    push_wr(2, 19'h01000);
    push_wr(3, 19'h01000);
    exp_spk.push_back(2'd0);
    exp_spk.push_back(2'd2);
    exp_spk.push_back(2'd3);
    accept_evt(EVT_TSTEP, 10'd0);
    wait_done(20, lat);
    check("t2_latency", lat, 6);
    repeat (3) @(negedge clk);

    // 3a) All over threshold, consumer stalled: FIFO fills to 4 without stalling the sweep.
    preset_all(19'h00200);
    @(posedge clk);
    #1 u_if.spk_ready = 1'b0;
    for (int j = 0; j < N_NEUR; j++) begin
      push_wr(j, 19'h01000);
      exp_spk.push_back(NRN_AW'(j));
    end
    accept_evt(EVT_TSTEP, 10'd0);
    wait_done(20, lat);
    check("t3_latency", lat, 6);
    check("t3_fifo_holds", u_if.spk_valid, 1);

    // 3b) Second TSTEP with a full FIFO must hold issue until slots free up.
    preset_all(19'h00200);
    for (int j = 0; j < N_NEUR; j++) begin
      push_wr(j, 19'h01000);
      exp_spk.push_back(NRN_AW'(j));
    end
    accept_evt(EVT_TSTEP, 10'd0);
    nre = 0;
    repeat (8) begin
      @(negedge clk);
      nre += int'(nrn_re);
    end
    check("t3_stall_no_issue", nre, 0);
    check("t3_stall_busy", busy, 1);
    @(posedge clk);
    #1 u_if.spk_ready = 1'b1;
    wait_done(100, lat);
    check("t3_resume_done", lat > 0, 1);
    repeat (6) @(negedge clk);
    check("t3_spk_drained", exp_spk.size(), 0);

    // 4) TREF clears every word and produces no spikes despite high state.
    preset_all(19'h05300);
    for (int j = 0; j < N_NEUR; j++) push_wr(j, 19'h00000);
    accept_evt(EVT_TREF, 10'd0);
    wait_done(20, lat);
    check("t4_latency", lat, 6);
    repeat (3) @(negedge clk);

    // 5) Reset while issuing j=2: only j=0 was written.
    push_wr(0, 19'h00040);
    accept_evt(EVT_NEURON, 10'd3);
    nre = 0;
    i = 0;
    while (nre < 2 && i < 50) begin
      @(negedge clk);
      i++;
      if (nrn_re) nre++;
    end
    check("t5_issue_reached", nre, 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("t5_abort_outs", outs_vec(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    i = 0;
    while (!u_if.evt_ready && i < 10) begin
      @(negedge clk);
      i++;
    end
    check("t5_ready_after_release", u_if.evt_ready, 1);
    check("t5_spk_empty", u_if.spk_valid, 0);
    check("t5_writes_before_abort", exp_wr.size(), 0);
    push_wr(0, 19'h00080);
    push_wr(1, 19'h00040);
    push_wr(2, 19'h00040);
    push_wr(3, 19'h00040);
    accept_evt(EVT_NEURON, 10'd3);
    wait_done(20, lat);
    check("t5_latency", lat, 6);
    repeat (2) @(negedge clk);

    // 6) Reserved type: no SRAM traffic, done one cycle after accept.
    accept_evt(EVT_RSVD, 10'd0);
    @(negedge clk);
    check("t6_done", done, 1);
    check("t6_no_access", {syn_re, nrn_re, nrn_we}, 0);
    @(negedge clk);
    check("t6_done_pulse", done, 0);
    check("t6_no_access_after", {syn_re, nrn_re, nrn_we}, 0);
    check("t6_evt_ready", u_if.evt_ready, 1);

    repeat (4) @(negedge clk);
    check("final_wr_queue", exp_wr.size(), 0);
    check("final_spk_queue", exp_spk.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
